// File: rtl/fdtd_axi_pkg.sv
// Shared AXI4 definitions for the FDTD plugin masters: response codes,
// burst/size encodings and the read-master FSM state type.
package fdtd_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        RS_IDLE = 2'b00,
        RS_ADDR = 2'b01,
        RS_READ = 2'b10,
        RS_DONE = 2'b11
    } rd_state_e;

endpackage

// File: rtl/fdtd_mem_rd_if.sv
// AXI4 read-channel bundle (AR + R) between the FDTD read master and the
// interconnect. Signal suffixes are from the master's point of view.
interface fdtd_mem_rd_if #(
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH = 32,
    parameter int AXI4_ID_WIDTH   = 16,
    parameter int AXI4_USER_WIDTH = 10
);
    logic [AXI4_ID_WIDTH-1:0]   ARID_o;
    logic [AXI4_ADDR_WIDTH-1:0] ARADDR_o;
    logic [7:0]                 ARLEN_o;
    logic [2:0]                 ARSIZE_o;
    logic [1:0]                 ARBURST_o;
    logic                       ARLOCK_o;
    logic [3:0]                 ARCACHE_o;
    logic [2:0]                 ARPROT_o;
    logic [3:0]                 ARREGION_o;
    logic [AXI4_USER_WIDTH-1:0] ARUSER_o;
    logic [3:0]                 ARQOS_o;
    logic                       ARVALID_o;
    logic                       ARREADY_i;

    logic [AXI4_ID_WIDTH-1:0]   RID_i;
    logic [AXI4_DATA_WIDTH-1:0] RDATA_i;
    logic [1:0]                 RRESP_i;
    logic                       RLAST_i;
    logic [AXI4_USER_WIDTH-1:0] RUSER_i;
    logic                       RVALID_i;
    logic                       RREADY_o;

    modport master (
        output ARID_o, ARADDR_o, ARLEN_o, ARSIZE_o, ARBURST_o, ARLOCK_o,
               ARCACHE_o, ARPROT_o, ARREGION_o, ARUSER_o, ARQOS_o, ARVALID_o,
               RREADY_o,
        input  ARREADY_i, RID_i, RDATA_i, RRESP_i, RLAST_i, RUSER_i, RVALID_i
    );

    modport slave (
        input  ARID_o, ARADDR_o, ARLEN_o, ARSIZE_o, ARBURST_o, ARLOCK_o,
               ARCACHE_o, ARPROT_o, ARREGION_o, ARUSER_o, ARQOS_o, ARVALID_o,
               RREADY_o,
        output ARREADY_i, RID_i, RDATA_i, RRESP_i, RLAST_i, RUSER_i, RVALID_i
    );

endinterface

// File: rtl/fdtd_mem_rd.sv
// FDTD AXI4 burst read master: one INCR burst per req/gnt request, R beats
// streamed to the datapath with valid/ready.
// Optional macro FDTD_MEM_RD_ERR_EN adds sticky rd_err_o (bad RRESP or
// RLAST disagreeing with the beat counter).
//
// state   | meaning
// RS_IDLE | waiting for rd_req_i, latches addr/len on accept
// RS_ADDR | ARVALID high until ARREADY
// RS_READ | forwarding R beats, counting accepted beats
// RS_DONE | one-cycle cooldown so a held rd_req_i is not re-accepted
module fdtd_mem_rd
    import fdtd_axi_pkg::*;
#(
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH = 32,
    parameter int AXI4_ID_WIDTH   = 16,
    parameter int AXI4_USER_WIDTH = 10
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    fdtd_mem_rd_if.master              axi,
    input  logic [7:0]                 axi_lenth_i,
    input  logic                       rd_req_i,
    input  logic [AXI4_ADDR_WIDTH-1:0] rd_word_addr_i,
    output logic [AXI4_DATA_WIDTH-1:0] rd_data_o,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic                       rd_gnt_o
`ifdef FDTD_MEM_RD_ERR_EN
    ,
    output logic                       rd_err_o
`endif
);

    rd_state_e                  state_q, state_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic [7:0]                 len_q, len_d;
    logic [AXI4_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                 arlen;
    logic                       in_read, beat, cnt_at_end, last_beat, arvalid;

    // len 0 wraps to 255, i.e. a 256-beat burst
    assign arlen      = len_q - 8'd1;
    assign in_read    = (state_q == RS_READ);
    assign beat       = in_read && axi.RVALID_i && rd_ready_i;
    assign cnt_at_end = (cnt_q == arlen);
    assign last_beat  = beat && cnt_at_end;

    assign axi.ARID_o     = '0;
    assign axi.ARADDR_o   = addr_q;
    assign axi.ARLEN_o    = arlen;
    assign axi.ARSIZE_o   = AXI_SIZE_4B;
    assign axi.ARBURST_o  = AXI_BURST_INCR;
    assign axi.ARLOCK_o   = 1'b0;
    assign axi.ARCACHE_o  = '0;
    assign axi.ARPROT_o   = '0;
    assign axi.ARREGION_o = '0;
    assign axi.ARUSER_o   = '0;
    assign axi.ARQOS_o    = '0;
    assign axi.ARVALID_o  = arvalid;
    assign axi.RREADY_o   = in_read && rd_ready_i;

    assign rd_data_o  = axi.RDATA_i;
    assign rd_valid_o = in_read && axi.RVALID_i;
    assign rd_gnt_o   = last_beat;

    // next-state, beat counter and request latch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        addr_d  = addr_q;
        arvalid = 1'b0;
        case (state_q)
            RS_IDLE: begin
                if (rd_req_i) begin
                    addr_d  = rd_word_addr_i;
                    len_d   = axi_lenth_i;
                    cnt_d   = 8'd0;
                    state_d = RS_ADDR;
                end
            end
            RS_ADDR: begin
                arvalid = 1'b1;
                if (axi.ARREADY_i) state_d = RS_READ;
            end
            RS_READ: begin
                if (beat) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_at_end) state_d = RS_DONE;
                end
            end
            RS_DONE: begin
                cnt_d   = 8'd0;
                state_d = RS_IDLE;
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = RS_IDLE;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= RS_IDLE;
            cnt_q   <= 8'd0;
            len_q   <= 8'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
        end
    end

`ifdef FDTD_MEM_RD_ERR_EN
    logic err_q, err_d;
    logic unused_r;
    assign unused_r = ^{axi.RID_i, axi.RUSER_i};

    // sticky error, cleared when the next request is accepted
    always_comb begin
        err_d = err_q;
        if (state_q == RS_IDLE && rd_req_i) begin
            err_d = 1'b0;
        end else if (beat && ((axi.RRESP_i != AXI_RESP_OKAY) ||
                              (axi.RLAST_i != cnt_at_end))) begin
            err_d = 1'b1;
        end
    end

    // error flag register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign rd_err_o = err_q;
`else
    logic unused_r;
    assign unused_r = ^{axi.RID_i, axi.RUSER_i, axi.RRESP_i, axi.RLAST_i};
`endif

endmodule

// File: tb/tb_fdtd_mem_rd.sv
// Scoreboard bench for fdtd_mem_rd: driver pushes expected AR/beat records,
// an AXI slave model serves the bursts, a negedge monitor pops and compares.
// Define FDTD_MEM_RD_ERR_EN to also exercise rd_err_o.
module tb_fdtd_mem_rd;
    import fdtd_axi_pkg::*;

    localparam int AW = 32, DW = 32, IW = 16, UW = 10;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [7:0]    axi_lenth_i = 8'd0;
    logic          rd_req_i = 1'b0;
    logic [AW-1:0] rd_word_addr_i = '0;
    logic [DW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic          rd_ready_i;
    logic          rd_gnt_o;
`ifdef FDTD_MEM_RD_ERR_EN
    logic          rd_err_o;
`endif

    fdtd_mem_rd_if #(.AXI4_ADDR_WIDTH(AW), .AXI4_DATA_WIDTH(DW),
                     .AXI4_ID_WIDTH(IW), .AXI4_USER_WIDTH(UW)) axi_if ();

    fdtd_mem_rd #(.AXI4_ADDR_WIDTH(AW), .AXI4_DATA_WIDTH(DW),
                  .AXI4_ID_WIDTH(IW), .AXI4_USER_WIDTH(UW)) dut (
        .ACLK           (ACLK),
        .ARESETn        (ARESETn),
        .axi            (axi_if),
        .axi_lenth_i    (axi_lenth_i),
        .rd_req_i       (rd_req_i),
        .rd_word_addr_i (rd_word_addr_i),
        .rd_data_o      (rd_data_o),
        .rd_valid_o     (rd_valid_o),
        .rd_ready_i     (rd_ready_i),
        .rd_gnt_o       (rd_gnt_o)
`ifdef FDTD_MEM_RD_ERR_EN
        ,
        .rd_err_o       (rd_err_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    typedef struct { logic [AW-1:0] addr; logic [7:0] arlen; int dly; } ar_t;
    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic rlast; } sl_beat_t;

    ar_t      ar_exp_q[$];
    beat_t    exp_q[$];
    sl_beat_t sl_beat_q[$];
    int       sl_n_q[$];
    int       sl_dly_q[$];

    int rdy_mode = 0;   // 0 random, 1 toggle, 2 always ready
    bit no_gaps  = 0;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // datapath ready generator
    initial begin
        rd_ready_i = 1'b1;
        forever begin
            @(posedge ACLK); #1;
            case (rdy_mode)
                0:       rd_ready_i = ($urandom_range(0, 3) != 0);
                1:       rd_ready_i = ~rd_ready_i;
                default: rd_ready_i = 1'b1;
            endcase
        end
    end

    // AXI slave model: serves each AR with the beats the driver queued
    initial begin
        int n, dly;
        bit hs;
        sl_beat_t b;
        axi_if.ARREADY_i = 1'b0;
        axi_if.RVALID_i  = 1'b0;
        axi_if.RDATA_i   = '0;
        axi_if.RRESP_i   = AXI_RESP_OKAY;
        axi_if.RLAST_i   = 1'b0;
        axi_if.RID_i     = '0;
        axi_if.RUSER_i   = '0;
        forever begin
            for (int w = 0; w < 5000 && !(axi_if.ARVALID_o && ARESETn); w++) begin
                @(posedge ACLK); #1;
            end
            if (!(axi_if.ARVALID_o && ARESETn)) continue;
            dly = (sl_dly_q.size() != 0) ? sl_dly_q.pop_front() : 0;
            n   = (sl_n_q.size() != 0) ? sl_n_q.pop_front() : 1;
            repeat (dly) begin @(posedge ACLK); #1; end
            axi_if.ARREADY_i = 1'b1;
            @(posedge ACLK); #1;
            axi_if.ARREADY_i = 1'b0;
            for (int i = 0; i < n && ARESETn; i++) begin
                if (!no_gaps && $urandom_range(0, 2) == 0) begin
                    axi_if.RVALID_i = 1'b0;
                    repeat ($urandom_range(1, 2)) begin @(posedge ACLK); #1; end
                end
                if (sl_beat_q.size() != 0) b = sl_beat_q.pop_front();
                else b = '{data: '0, resp: AXI_RESP_OKAY, rlast: 1'b0};
                axi_if.RVALID_i = 1'b1;
                axi_if.RDATA_i  = b.data;
                axi_if.RRESP_i  = b.resp;
                axi_if.RLAST_i  = b.rlast;
                axi_if.RID_i    = IW'($urandom);
                axi_if.RUSER_i  = UW'($urandom);
                hs = 1'b0;
                for (int w = 0; w < 2000 && !hs && ARESETn; w++) begin
                    @(negedge ACLK);
                    hs = axi_if.RREADY_o;
                    @(posedge ACLK); #1;
                end
            end
            axi_if.RVALID_i = 1'b0;
            axi_if.RLAST_i  = 1'b0;
            if (!ARESETn) begin
                sl_beat_q.delete();
                sl_n_q.delete();
                sl_dly_q.delete();
                for (int w = 0; w < 1000 && !ARESETn; w++) begin @(posedge ACLK); #1; end
            end
        end
    end

    // monitor: AR channel properties, beat scoreboard, gnt and error model
    int            arv_cnt = 0;
    bit            ar_hold = 0;
    logic [AW-1:0] hold_addr;
    logic [7:0]    hold_len;
    bit            gnt_seen = 0;
    int            gnt_cyc = 0;
    bit            err_model = 0;

    always @(negedge ACLK) begin
        ar_t   e;
        beat_t b;
        if (!ARESETn) begin
            arv_cnt   = 0;
            ar_hold   = 0;
            gnt_seen  = 0;
            err_model = 0;
        end else begin
            if (ar_hold) begin
                check("arvalid_held", axi_if.ARVALID_o, 1'b1);
                check("ar_stable", {axi_if.ARADDR_o, axi_if.ARLEN_o}, {hold_addr, hold_len});
            end
            if (axi_if.ARVALID_o) begin
                if (arv_cnt == 0 && gnt_seen)
                    check("gnt_to_arvalid_gap_ge3", (cyc - gnt_cyc) >= 3, 1'b1);
                arv_cnt++;
                if (axi_if.ARREADY_i) begin
                    if (ar_exp_q.size() == 0) begin
                        fail_now("unexpected_ar");
                    end else begin
                        e = ar_exp_q.pop_front();
                        check("araddr", axi_if.ARADDR_o, e.addr);
                        check("arlen", axi_if.ARLEN_o, e.arlen);
                        check("arvalid_cycles", arv_cnt, e.dly + 1);
                        check("arsize", axi_if.ARSIZE_o, 3'd2);
                        check("arburst", axi_if.ARBURST_o, 2'b01);
                        check("ar_zero_fields", {axi_if.ARID_o, axi_if.ARLOCK_o, axi_if.ARCACHE_o,
                              axi_if.ARPROT_o, axi_if.ARREGION_o, axi_if.ARUSER_o, axi_if.ARQOS_o}, 0);
                    end
`ifdef FDTD_MEM_RD_ERR_EN
                    check("err_cleared_on_accept", rd_err_o, 1'b0);
`endif
                    err_model = 0;
                    arv_cnt = 0;
                    ar_hold = 0;
                end else begin
                    ar_hold   = 1;
                    hold_addr = axi_if.ARADDR_o;
                    hold_len  = axi_if.ARLEN_o;
                end
            end else begin
                ar_hold = 0;
            end
            if (rd_valid_o) check("rready_mirrors_ready", axi_if.RREADY_o, rd_ready_i);
            if (rd_gnt_o && !(rd_valid_o && rd_ready_i)) fail_now("gnt_without_beat");
            if (rd_valid_o && rd_ready_i) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    b = exp_q.pop_front();
                    check("rd_data", rd_data_o, b.data);
                    check("rd_gnt", rd_gnt_o, b.last);
`ifdef FDTD_MEM_RD_ERR_EN
                    check("rd_err", rd_err_o, err_model);
`endif
                    err_model = err_model || (axi_if.RRESP_i != AXI_RESP_OKAY) ||
                                (axi_if.RLAST_i != b.last);
                end
                if (rd_gnt_o) begin
                    gnt_seen = 1;
                    gnt_cyc  = cyc;
                end
            end
        end
    end

    // issue one request; err_beat >= 0 forces SLVERR there and OKAY elsewhere
    task automatic run_burst(input logic [AW-1:0] addr, input logic [7:0] len, input int dly,
                             input bit use_d0, input logic [DW-1:0] d0, input int err_beat);
        int n;
        bit got;
        sl_beat_t sb;
        logic [1:0] codes [4];
        codes[0] = AXI_RESP_OKAY;   codes[1] = AXI_RESP_EXOKAY;
        codes[2] = AXI_RESP_SLVERR; codes[3] = AXI_RESP_DECERR;
        n = (len == 8'd0) ? 256 : int'(len);
        ar_exp_q.push_back('{addr: addr, arlen: 8'(n - 1), dly: dly});
        sl_n_q.push_back(n);
        sl_dly_q.push_back(dly);
        for (int i = 0; i < n; i++) begin
            sb.data  = (i == 0 && use_d0) ? d0 : $urandom;
            sb.rlast = (i == n - 1);
            if (err_beat >= 0) begin
                sb.resp = (i == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end else begin
                sb.resp = ($urandom_range(0, 7) == 0) ? codes[$urandom_range(0, 3)] : AXI_RESP_OKAY;
                if ($urandom_range(0, 15) == 0) sb.rlast = ~sb.rlast;
            end
            sl_beat_q.push_back(sb);
            exp_q.push_back('{data: sb.data, last: (i == n - 1)});
        end
        rd_word_addr_i = addr;
        axi_lenth_i    = len;
        rd_req_i       = 1'b1;
        got = 0;
        for (int w = 0; w < n * 40 + 200 && !got; w++) begin
            @(negedge ACLK);
            got = rd_gnt_o;
        end
        if (!got) fail_now("gnt_timeout");
    endtask

    initial begin
        int len;
        // reset state
        repeat (2) @(posedge ACLK);
        #1;
        check("rst_arvalid", axi_if.ARVALID_o, 1'b0);
        check("rst_rd_valid", rd_valid_o, 1'b0);
        check("rst_rd_gnt", rd_gnt_o, 1'b0);
        check("rst_rready", axi_if.RREADY_o, 1'b0);
        check("rst_araddr", axi_if.ARADDR_o, 0);
        check("rst_arlen", axi_if.ARLEN_o, 8'd255);
`ifdef FDTD_MEM_RD_ERR_EN
        check("rst_err", rd_err_o, 1'b0);
`endif
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // single beat, immediate ARREADY
        rdy_mode = 2;
        run_burst(32'h1000_0040, 8'd1, 0, 1'b1, 32'hDEAD_BEEF, -1);
        @(posedge ACLK); #1;
        rd_req_i = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;

        // 16 beats, ARREADY delayed 3 cycles
        rdy_mode = 0;
        run_burst(32'h2000_0100, 8'd16, 3, 1'b0, '0, -1);

        // backpressure, RVALID continuously high
        rdy_mode = 1;
        no_gaps  = 1;
        run_burst(32'h2000_0200, 8'd8, 1, 1'b0, '0, -1);
        no_gaps  = 0;
        rdy_mode = 0;

        // 256-beat burst from len 0
        run_burst(32'h3000_0000, 8'd0, 2, 1'b0, '0, -1);

        // SLVERR on beat 2 of 4
        run_burst(32'h4000_0010, 8'd4, 0, 1'b0, '0, 1);
`ifdef FDTD_MEM_RD_ERR_EN
        @(posedge ACLK); #1;
        check("err_sticky_after_gnt", rd_err_o, 1'b1);
`endif

        // randomized bursts, mixing back-to-back and idle gaps
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(posedge ACLK); #1;
                rd_req_i = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge ACLK);
                #1;
            end
            len = $urandom_range(1, 24);
            rdy_mode = $urandom_range(0, 2);
            run_burst({$urandom} & 32'hFFFF_FFFC, 8'(len), $urandom_range(0, 4), 1'b0, '0, -1);
        end
        @(posedge ACLK); #1;
        rd_req_i = 1'b0;
        rdy_mode = 2;
        no_gaps  = 1;
        repeat (4) @(posedge ACLK);
        #1;

        // reset after beat 3 of 8
        ar_exp_q.push_back('{addr: 32'h5000_0000, arlen: 8'd7, dly: 0});
        sl_n_q.push_back(8);
        sl_dly_q.push_back(0);
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] d;
            d = $urandom;
            sl_beat_q.push_back('{data: d, resp: AXI_RESP_OKAY, rlast: (i == 7)});
            exp_q.push_back('{data: d, last: (i == 7)});
        end
        rd_word_addr_i = 32'h5000_0000;
        axi_lenth_i    = 8'd8;
        rd_req_i       = 1'b1;
        for (int w = 0; w < 200 && exp_q.size() > 5; w++) begin @(posedge ACLK); #1; end
        rd_req_i = 1'b0;
        if (exp_q.size() != 5) fail_now("reset_test_beats_timeout");
        #2;
        ARESETn = 1'b0;
        #1;
        check("midrst_arvalid", axi_if.ARVALID_o, 1'b0);
        check("midrst_rd_valid", rd_valid_o, 1'b0);
        check("midrst_rready", axi_if.RREADY_o, 1'b0);
        check("midrst_gnt", rd_gnt_o, 1'b0);
`ifdef FDTD_MEM_RD_ERR_EN
        check("midrst_err", rd_err_o, 1'b0);
`endif
        exp_q.delete();
        ar_exp_q.delete();
        repeat (3) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        no_gaps  = 0;
        rdy_mode = 0;
        @(posedge ACLK); #1;
        run_burst(32'h6000_0020, 8'd4, 1, 1'b0, '0, -1);
        @(posedge ACLK); #1;
        rd_req_i = 1'b0;
        repeat (5) @(posedge ACLK);
        #1;

        check("leftover_beats", exp_q.size(), 0);
        check("leftover_ar", ar_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fdtd_mem_rd.md
Name: fdtd_mem_rd

Overview:
AXI4 burst read master for the FDTD user plugin, the read-side counterpart of the plugin's AXI4 write master. It takes a simple req/gnt request from the FDTD datapath and issues one INCR burst on the AR channel. It streams each R beat back to the datapath with valid/ready flow control. It sits between the FDTD compute engine and the PULPino AXI interconnect slave port.

Parameters:
AXI4_ADDR_WIDTH, 32, AR address width (byte address)
AXI4_DATA_WIDTH, 32, R data width
AXI4_ID_WIDTH, 16, ARID/RID width
AXI4_USER_WIDTH, 10, ARUSER/RUSER width

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
ARID_o  out  ID_W  constant 0
ARADDR_o  out  ADDR_W  burst start byte address
ARLEN_o  out  8  beats-1
ARSIZE_o  out  3  constant 2 (4 bytes)
ARBURST_o  out  2  constant 2'b01 (INCR)
ARLOCK_o / ARCACHE_o / ARPROT_o / ARREGION_o / ARUSER_o / ARQOS_o  out  1/4/3/4/USER_W/4  constant 0
ARVALID_o  out  1  address valid
ARREADY_i  in  1  address ready
RID_i  in  ID_W  ignored
RDATA_i  in  DATA_W  read data
RRESP_i  in  2  response
RLAST_i  in  1  last beat
RUSER_i  in  USER_W  ignored
RVALID_i  in  1  data valid
RREADY_o  out  1  data ready
axi_lenth_i  in  8  beats per burst (1..255; 0 means 256)
rd_req_i  in  1  request; held high with addr/len stable until rd_gnt_o
rd_word_addr_i  in  ADDR_W  start byte address
rd_data_o  out  DATA_W  beat data
rd_valid_o  out  1  beat valid
rd_ready_i  in  1  datapath accepts beat
rd_gnt_o  out  1  one-cycle pulse: burst complete

Behaviour:
- Reset is asynchronous and active-low: state RS_IDLE, beat counter 0, latched addr/len 0. All valid/gnt outputs are 0.
- Addr and len are registered when the request is accepted in RS_IDLE. ARADDR_o/ARLEN_o are driven from these registers. ARLEN_o = len-1 in 8-bit arithmetic, so len 0 gives 255, i.e. 256 beats.
- rd_data_o = RDATA_i, rd_valid_o = RVALID_i in RS_READ, RREADY_o = rd_ready_i in RS_READ. These paths are combinational, with zero latency.
- FSM (2-bit state):
  - RS_IDLE: if rd_req_i, latch addr/len and go to RS_ADDR.
  - RS_ADDR: ARVALID_o=1, held until ARREADY_i. On ARREADY_i go to RS_READ. ARVALID never drops before the handshake.
  - RS_READ: each RVALID_i&&RREADY_o increments the beat counter. The burst ends on the beat where the counter equals the latched ARLEN. On that beat, rd_gnt_o pulses and the FSM moves to RS_DONE.
  - RS_DONE: one cycle. Counter cleared, then go to RS_IDLE. This stops a still-high rd_req_i from being re-accepted in the grant cycle.
- RLAST_i consistency: if RLAST_i is asserted on a beat where count != ARLEN, or is absent on the final counted beat, the counter still governs completion. The mismatch is reported only under the optional feature.
- The beat counter is 8-bit and wraps 255→0 only after the final beat of a 256-beat burst.
- Back-to-back bursts: minimum 2 idle cycles between rd_gnt_o and the next ARVALID_o.
- Reset mid-burst aborts immediately with no further handshakes. The interconnect is reset in the same domain.
- The illegal state encoding recovers to RS_IDLE.

Optional Feature:
Macro FDTD_MEM_RD_ERR_EN.
- With the macro: extra output port rd_err_o (1 bit, reset 0). It is set sticky if any accepted beat has RRESP_i != OKAY (2'b00), or on an RLAST_i/counter mismatch. It is cleared when a new request is accepted in RS_IDLE. Data is still forwarded.
- Without the macro: the port is absent, and RRESP_i and RLAST_i are ignored.

Decomposition:
- Package fdtd_axi_pkg holds:
  - the OKAY/EXOKAY/SLVERR/DECERR localparams
  - the AXI_BURST_INCR and AXI_SIZE_4B constants
  - the rd FSM state enum typedef
- The write master moves its `define response codes to this package.
- No sub-module: the beat counter and FSM stay inline.

Test Plan:
- Single beat: len=1, addr=0x1000_0040, ARREADY immediate, one R beat 0xDEADBEEF → ARLEN_o=0. rd_valid_o shows 0xDEADBEEF, rd_gnt_o pulses on that beat, and the FSM is idle 2 cycles later.
- 16-beat burst with ARREADY delayed 3 cycles → ARVALID_o held 4 cycles with stable ARADDR/ARLEN=15. 16 beats are forwarded in order, with gnt on beat 16 only.
- Backpressure: len=8, rd_ready_i toggled 1/0 each cycle, RVALID_i always high → RREADY_o mirrors rd_ready_i. Exactly 8 accepted beats, no beat lost or duplicated.
- len=0 → ARLEN_o=255. 256 beats are accepted and gnt fires on beat 256; the counter returns to 0.
- ARESETn asserted after beat 3 of 8 → all outputs are 0 asynchronously. A new request after reset starts cleanly with ARVALID_o.
- With FDTD_MEM_RD_ERR_EN defined: beat 2 of 4 returns RRESP=SLVERR → rd_err_o goes to 1 after that beat and stays 1 through gnt. It clears on the next accepted request.
